// File: rtl/reaction_timer.sv
// Reaction timer: arms on the start trigger, measures ms from lights-out to the
// first button press, flags false starts and timeouts, and tracks the best time.
module reaction_timer #(
    parameter int MAX_MS = 9999,
    parameter int W      = 14
) (
    input  logic         i_clk,
    input  logic         i_arst,
    input  logic         i_tick,
    input  logic         i_trigger,
    input  logic         i_lightsOut,
    input  logic         i_button,
    input  logic         i_clear,
    output logic [W-1:0] o_reactionMs,
    output logic [W-1:0] o_bestMs,
    output logic         o_valid,
    output logic         o_done,
    output logic         o_falseStart,
    output logic         o_timeout
);

    typedef enum logic [1:0] {IDLE, ARMED, TIMING, DONE} state_t;

    localparam logic [W-1:0] MAX_V = W'(MAX_MS);

    state_t       state_r, state_nxt_s;
    logic         sync1_r, sync2_r, sync3_r;
    logic         press_s;
    logic [W-1:0] count_r, count_nxt_s;
    logic [W:0]   sum_s;
    logic [W-1:0] react_r, react_nxt_s;
    logic [W-1:0] best_r, best_nxt_s;
    logic         valid_r, valid_nxt_s;
    logic         done_r, done_nxt_s;
    logic         fs_r, fs_nxt_s;
    logic         to_r, to_nxt_s;

    // Button synchronizer plus one-cycle history for rising-edge detection
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= i_button;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign press_s = sync2_r & ~sync3_r;
    // Time including a tick arriving in the current cycle
    assign sum_s   = {1'b0, count_r} + {{W{1'b0}}, i_tick};

    // Next-state and next-result logic; clear overrides every state
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        react_nxt_s = react_r;
        best_nxt_s  = best_r;
        valid_nxt_s = valid_r;
        fs_nxt_s    = fs_r;
        to_nxt_s    = to_r;
        if (i_clear) begin
            state_nxt_s = IDLE;
            count_nxt_s = {W{1'b0}};
            react_nxt_s = {W{1'b0}};
            best_nxt_s  = MAX_V;
            valid_nxt_s = 1'b0;
            fs_nxt_s    = 1'b0;
            to_nxt_s    = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_trigger) begin
                        state_nxt_s = ARMED;
                        valid_nxt_s = 1'b0;
                        fs_nxt_s    = 1'b0;
                        to_nxt_s    = 1'b0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ARMED: begin
                    if (press_s) begin
                        state_nxt_s = DONE;
                        react_nxt_s = {W{1'b0}};
                        valid_nxt_s = 1'b1;
                        fs_nxt_s    = 1'b1;
                        to_nxt_s    = 1'b0;
                    end else if (i_lightsOut) begin
                        state_nxt_s = TIMING;
                        count_nxt_s = {W{1'b0}};
                    end else begin
                        state_nxt_s = ARMED;
                    end
                end
                TIMING: begin
                    // A press in the timeout cycle still counts as a valid result
                    if (press_s) begin
                        state_nxt_s = DONE;
                        count_nxt_s = sum_s[W-1:0];
                        react_nxt_s = sum_s[W-1:0];
                        valid_nxt_s = 1'b1;
                        fs_nxt_s    = 1'b0;
                        to_nxt_s    = 1'b0;
                        if (sum_s[W-1:0] < best_r) begin
                            best_nxt_s = sum_s[W-1:0];
                        end else begin
                            best_nxt_s = best_r;
                        end
                    end else if (sum_s >= {1'b0, MAX_V}) begin
                        state_nxt_s = DONE;
                        count_nxt_s = MAX_V;
                        react_nxt_s = MAX_V;
                        valid_nxt_s = 1'b1;
                        fs_nxt_s    = 1'b0;
                        to_nxt_s    = 1'b1;
                    end else begin
                        count_nxt_s = sum_s[W-1:0];
                    end
                end
                DONE: begin
                    if (i_trigger) begin
                        state_nxt_s = ARMED;
                        valid_nxt_s = 1'b0;
                        fs_nxt_s    = 1'b0;
                        to_nxt_s    = 1'b0;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
        done_nxt_s = (state_nxt_s == DONE) && (state_r != DONE);
    end

    // State, counter and result registers
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_r <= IDLE;
            count_r <= {W{1'b0}};
            react_r <= {W{1'b0}};
            best_r  <= MAX_V;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            fs_r    <= 1'b0;
            to_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            react_r <= react_nxt_s;
            best_r  <= best_nxt_s;
            valid_r <= valid_nxt_s;
            done_r  <= done_nxt_s;
            fs_r    <= fs_nxt_s;
            to_r    <= to_nxt_s;
        end
    end

    assign o_reactionMs = react_r;
    assign o_bestMs     = best_r;
    assign o_valid      = valid_r;
    assign o_done       = done_r;
    assign o_falseStart = fs_r;
    assign o_timeout    = to_r;

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: table-driven rounds, hand-written
// corner cases, and randomized rounds checked against a round-level model.
module tb_reaction_timer;

    localparam int MAX_MS = 9999;
    localparam int W      = 14;

    logic         clk = 1'b0;
    logic         arst, tick, trigger, lights_out, button, clear;
    logic [W-1:0] reaction_ms, best_ms;
    logic         valid, done, false_start, timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int model_best;

    reaction_timer #(.MAX_MS(MAX_MS), .W(W)) dut (
        .i_clk(clk), .i_arst(arst), .i_tick(tick), .i_trigger(trigger),
        .i_lightsOut(lights_out), .i_button(button), .i_clear(clear),
        .o_reactionMs(reaction_ms), .o_bestMs(best_ms), .o_valid(valid),
        .o_done(done), .o_falseStart(false_start), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit clr;
        int n;
        bit last;
        bit early;
        int exp_react;
        bit exp_fs;
        int exp_best;
    } rec_t;

    rec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge
    task automatic step(input logic t, input logic tr, input logic lo, input logic b, input logic cl);
        tick = t; trigger = tr; lights_out = lo; button = b; clear = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic release_button();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clear(input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        model_best = MAX_MS;
        chk({tag, "_clr_best"}, int'(best_ms), MAX_MS);
        chk({tag, "_clr_valid"}, int'(valid), 0);
        chk({tag, "_clr_react"}, int'(reaction_ms), 0);
    endtask

    // One round: trigger, optional lights-out and n ticks, then a press whose
    // capture edge carries tick value 'last'
    task automatic run_round(input int n, input bit last, input bit early, input int gap_max,
                             input int exp_react, input bit exp_fs, input int exp_best,
                             input string tag);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk({tag, "_armed_valid"}, int'(valid), 0);
        chk({tag, "_armed_fs"}, int'(false_start), 0);
        if (early) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end else begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < n; i++) begin
                int g;
                g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
                for (int j = 0; j < g; j++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step(last, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_valid"}, int'(valid), 1);
        chk({tag, "_react"}, int'(reaction_ms), exp_react);
        chk({tag, "_fs"}, int'(false_start), int'(exp_fs));
        chk({tag, "_timeout"}, int'(timeout), 0);
        chk({tag, "_best"}, int'(best_ms), exp_best);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk({tag, "_done_pulse"}, int'(done), 0);
        chk({tag, "_valid_hold"}, int'(valid), 1);
        release_button();
    endtask

    initial begin
        tbl[0] = '{clr: 1'b0, n: 250,  last: 1'b0, early: 1'b0, exp_react: 250,  exp_fs: 1'b0, exp_best: 250};
        tbl[1] = '{clr: 1'b1, n: 300,  last: 1'b0, early: 1'b0, exp_react: 300,  exp_fs: 1'b0, exp_best: 300};
        tbl[2] = '{clr: 1'b0, n: 180,  last: 1'b0, early: 1'b0, exp_react: 180,  exp_fs: 1'b0, exp_best: 180};
        tbl[3] = '{clr: 1'b0, n: 220,  last: 1'b0, early: 1'b0, exp_react: 220,  exp_fs: 1'b0, exp_best: 180};
        tbl[4] = '{clr: 1'b0, n: 0,    last: 1'b0, early: 1'b1, exp_react: 0,    exp_fs: 1'b1, exp_best: 180};
        tbl[5] = '{clr: 1'b0, n: 99,   last: 1'b1, early: 1'b0, exp_react: 100,  exp_fs: 1'b0, exp_best: 100};
        tbl[6] = '{clr: 1'b0, n: 9998, last: 1'b1, early: 1'b0, exp_react: 9999, exp_fs: 1'b0, exp_best: 100};
        tbl[7] = '{clr: 1'b0, n: 0,    last: 1'b0, early: 1'b0, exp_react: 0,    exp_fs: 1'b0, exp_best: 0};
        tbl[8] = '{clr: 1'b0, n: 0,    last: 1'b1, early: 1'b0, exp_react: 1,    exp_fs: 1'b0, exp_best: 0};

        tick = 1'b0; trigger = 1'b0; lights_out = 1'b0; button = 1'b0; clear = 1'b0;
        arst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_react", int'(reaction_ms), 0);
        chk("rst_best", int'(best_ms), MAX_MS);
        chk("rst_flags", int'({valid, done, false_start, timeout}), 0);
        arst = 1'b0;
        model_best = MAX_MS;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("idle_ignores_lo", int'(valid), 0);

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].clr) do_clear($sformatf("tbl%0d", i));
            run_round(tbl[i].n, tbl[i].last, tbl[i].early, 0, tbl[i].exp_react,
                      tbl[i].exp_fs, tbl[i].exp_best, $sformatf("tbl%0d", i));
            model_best = tbl[i].exp_best;
        end

        // Press event in the same cycle as lights-out
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("simul_fs", int'(false_start), 1);
        chk("simul_react", int'(reaction_ms), 0);
        chk("simul_done", int'(done), 1);
        release_button();

        // Timeout after MAX_MS ticks with no press
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < MAX_MS - 1; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_not_yet", int'(valid), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("to_flag", int'(timeout), 1);
        chk("to_react", int'(reaction_ms), MAX_MS);
        chk("to_done", int'(done), 1);
        chk("to_best", int'(best_ms), model_best);
        chk("to_fs", int'(false_start), 0);

        // Held button across two rounds: only the first rising edge counts
        do_clear("hold");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hold_first", int'(reaction_ms), 10);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hold_no_press", int'(valid), 0);
        release_button();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hold_second", int'(reaction_ms), 50);
        chk("hold_best", int'(best_ms), 10);
        release_button();

        // Randomized rounds against a round-level model
        do_clear("rnd");
        for (int r = 0; r < 25; r++) begin
            bit early, last;
            int n, exp_react;
            early = ($urandom_range(0, 4) == 0);
            last  = 1'($urandom_range(0, 1));
            n     = $urandom_range(0, 400);
            exp_react = early ? 0 : n + int'(last);
            if (!early && exp_react < model_best) model_best = exp_react;
            run_round(n, last, early, 2, exp_react, early, model_best, $sformatf("rnd%0d", r));
        end

        // Asynchronous reset in the middle of TIMING
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 arst = 1'b1;
        #1;
        chk("arst_react", int'(reaction_ms), 0);
        chk("arst_best", int'(best_ms), MAX_MS);
        chk("arst_flags", int'({valid, done, false_start, timeout}), 0);
        @(posedge clk);
        #1 arst = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("arst_idle", int'(valid), 0);
        release_button();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
